// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and types, used by fetch_unit and decode_unit.
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries; DEPTH must be a power of two.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  fetch_entry_t  mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one-cycle memory, prefetch queue, branch redirect.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               is_branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_stall_cnt,
  output logic [15:0]        fetch_flush_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              infl_q, infl_d;
  logic [CW-1:0]     q_count, occ;
  logic              q_empty, head_valid, push, pop;
  fetch_entry_t      head, push_entry;

  // Requests are throttled so every in-flight response is guaranteed a slot.
  assign occ       = q_count + CW'(infl_q);
  assign imem_req  = !reset && !is_branch_taken && (occ < CW'(QDEPTH));
  assign imem_addr = pc_q;

  assign head_valid  = !q_empty && !reset;
  assign instr_valid = head_valid;
  assign instr       = head_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = head_valid ? head.pc : '0;

  assign push       = infl_q && !is_branch_taken && !reset;
  assign pop        = head_valid && !stall && !is_branch_taken;
  assign push_entry = '{pc: infl_pc_q, instr: imem_rdata};

  always_comb begin
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    if (is_branch_taken) begin
      pc_d = branch_target;
    end else if (imem_req) begin
      pc_d      = pc_q + ADDR_W'(1);
      infl_d    = 1'b1;
      infl_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      infl_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (is_branch_taken),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (instr_valid && stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (is_branch_taken && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
  assign fetch_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/branch/reset traffic.
module tb_fetch_unit;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset, stall, is_branch_taken;
  logic [15:0] branch_target, imem_addr, imem_rdata, instr, instr_pc;
  logic        imem_req, instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_stall_cnt, fetch_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(QD)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt),
    .fetch_flush_cnt (fetch_flush_cnt)
`endif
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    if (a < 16'd4) return (a + 16'd1) * 16'h1111;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Instruction memory: data one cycle after an accepted request, junk otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? mem_f(imem_addr) : 16'hDEAD;

  // Reference model: program-order stream of PCs awaiting delivery.
  logic [15:0] m_fpc = 16'h0000;
  bit          m_pend = 1'b0;
  logic [15:0] m_pend_pc = 16'h0000;
  logic [15:0] m_q[$];
  int          m_stall_cnt = 0;
  int          m_flush_cnt = 0;

  logic        obs_req, obs_valid;
  logic [15:0] obs_addr, obs_instr, obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit br, input logic [15:0] tgt, input bit st);
    bit          e_req, e_valid;
    logic [15:0] e_pc, e_instr;
    reset = rst; is_branch_taken = br; branch_target = tgt; stall = st;
    #1;
    e_valid = !rst && (m_q.size() > 0);
    e_req   = !rst && !br && ((m_q.size() + int'(m_pend)) < QD);
    e_pc    = 16'h0000;
    e_instr = 16'h0000;
    if (e_valid) begin
      e_pc    = m_q[0];
      e_instr = mem_f(m_q[0]);
    end
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
    obs_instr = instr; obs_pc = instr_pc;
    check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check("imem_addr", {16'd0, imem_addr}, {16'd0, m_fpc});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
    check("instr", {16'd0, instr}, {16'd0, e_instr});
    check("instr_pc", {16'd0, instr_pc}, {16'd0, e_pc});
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", {16'd0, fetch_stall_cnt}, 32'(m_stall_cnt));
    check("flush_cnt", {16'd0, fetch_flush_cnt}, 32'(m_flush_cnt));
`endif
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_pend = 1'b0; m_fpc = 16'h0000;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (e_valid && st && m_stall_cnt < 32'hFFFF) m_stall_cnt++;
      if (br && m_flush_cnt < 32'hFFFF) m_flush_cnt++;
      if (br) begin
        m_q.delete(); m_pend = 1'b0; m_fpc = tgt;
      end else begin
        if (e_valid && !st) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pend_pc);
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc = m_fpc;
          m_fpc     = m_fpc + 16'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  logic [15:0] rec_pc[8], rec_in[8];
  logic        rec_v[8], rec_req[8];
  logic [15:0] rec_addr[8];
  logic [15:0] held_in, held_pc;

  initial begin
    reset = 1'b1; stall = 1'b0; is_branch_taken = 1'b0; branch_target = 16'h0000;
    @(negedge clk);
    repeat (3) cyc(1, 0, 16'h0000, 0);

    // Cold start: first request immediately, two-cycle latency, back-to-back delivery.
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 16'h0000, 0);
      rec_v[i] = obs_valid; rec_in[i] = obs_instr; rec_pc[i] = obs_pc;
      rec_req[i] = obs_req; rec_addr[i] = obs_addr;
    end
    check("first_req", {31'd0, rec_req[0]}, 32'd1);
    check("first_addr", {16'd0, rec_addr[0]}, 32'h0000);
    check("lat_c1_valid", {31'd0, rec_v[1]}, 32'd0);
    check("lat_c2_valid", {31'd0, rec_v[2]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("seq_instr", {16'd0, rec_in[2+k]}, 32'((k + 1) * 32'h1111));
      check("seq_pc", {16'd0, rec_pc[2+k]}, 32'(k));
    end

    // Long stall fills the queue; head must hold and requests stop.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 16'h0000, 1);
      if (i == 0) begin held_in = obs_instr; held_pc = obs_pc; end
      check("stall_hold_instr", {16'd0, obs_instr}, {16'd0, held_in});
      check("stall_hold_pc", {16'd0, obs_pc}, {16'd0, held_pc});
    end
    check("stall_full_noreq", {31'd0, obs_req}, 32'd0);
    repeat (4) cyc(0, 0, 16'h0000, 0);

    // Redirect with a response in flight.
    cyc(0, 1, 16'h0040, 0);
    cyc(0, 0, 16'h0000, 0);
    check("br_valid0", {31'd0, obs_valid}, 32'd0);
    check("br_req", {31'd0, obs_req}, 32'd1);
    check("br_addr", {16'd0, obs_addr}, 32'h0040);
    cyc(0, 0, 16'h0000, 0);
    check("br_stale_gone", {31'd0, obs_valid}, 32'd0);
    cyc(0, 0, 16'h0000, 0);
    check("br_target_valid", {31'd0, obs_valid}, 32'd1);
    check("br_target_pc", {16'd0, obs_pc}, 32'h0040);

    // Branch wins over stall.
    repeat (2) cyc(0, 0, 16'h0000, 1);
    cyc(0, 1, 16'h0100, 1);
    cyc(0, 0, 16'h0000, 1);
    check("brst_flushed", {31'd0, obs_valid}, 32'd0);
    check("brst_addr", {16'd0, obs_addr}, 32'h0100);

    // PC wraps at the top of the address space.
    cyc(0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 16'h0000, 0);
      rec_pc[i] = obs_pc;
    end
    check("wrap_pc0", {16'd0, rec_pc[2]}, 32'hFFFE);
    check("wrap_pc1", {16'd0, rec_pc[3]}, 32'hFFFF);
    check("wrap_pc2", {16'd0, rec_pc[4]}, 32'h0000);
    check("wrap_pc3", {16'd0, rec_pc[5]}, 32'h0001);

    // Reset mid-operation outranks branch and stall.
    repeat (2) cyc(0, 0, 16'h0000, 1);
    cyc(1, 1, 16'h1234, 1);
    cyc(0, 0, 16'h0000, 0);
    check("midrst_valid", {31'd0, obs_valid}, 32'd0);
    check("midrst_addr", {16'd0, obs_addr}, 32'h0000);

`ifdef FETCH_PERF_CNT_EN
    cyc(1, 0, 16'h0000, 0);
    repeat (3) cyc(0, 0, 16'h0000, 0);
    repeat (3) cyc(0, 0, 16'h0000, 1);
    cyc(0, 1, 16'h0200, 0);
    cyc(0, 1, 16'h0300, 0);
    check("perf_stall3", {16'd0, fetch_stall_cnt}, 32'd3);
    check("perf_flush2", {16'd0, fetch_flush_cnt}, 32'd2);
    cyc(1, 0, 16'h0000, 0);
    check("perf_stall_clr", {16'd0, fetch_stall_cnt}, 32'd0);
    check("perf_flush_clr", {16'd0, fetch_flush_cnt}, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r < 2, (r >= 2) && (r < 8), 16'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the word address fetched first after reset.
REQ-002 Parameter QDEPTH, default 4, meaning the fetch-queue entry count (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  downstream decode stage cannot accept an instruction this cycle.
REQ-006 is_branch_taken  input  1  redirect request from downstream, valid this cycle.
REQ-007 branch_target  input  16  word address to fetch from when is_branch_taken=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  16  word address of the request.
REQ-010 imem_rdata  input  16  read data, valid exactly one cycle after an accepted imem_req.
REQ-011 instr  output  16  instruction at the queue head; 16'h0000 (NOP) when the queue is empty.
REQ-012 instr_valid  output  1  instr holds a real fetched instruction.
REQ-013 instr_pc  output  16  word address of instr; 16'h0000 when instr_valid=0.

Function
REQ-014 Fetch PC SHALL be a 16-bit word address, incremented by 1 per issued request, wrapping 16'hFFFF->16'h0000.
REQ-015 imem_req SHALL assert only when (occupancy + in-flight) < QDEPTH and is_branch_taken=0; imem_addr = fetch PC.
REQ-016 The response arriving one cycle after an issued request SHALL be pushed with its PC unless discarded (REQ-020).
REQ-017 The queue head SHALL drive instr/instr_pc combinationally; instr_valid = queue not empty.
REQ-018 Pop SHALL occur when instr_valid=1 and stall=0; with stall=1, instr/instr_pc/instr_valid SHALL hold unchanged.
REQ-019 Simultaneous push and pop SHALL keep occupancy constant; overflow is prevented by REQ-015, never by dropping data.
REQ-020 is_branch_taken=1 SHALL, in the same edge: empty the queue, mark any in-flight response discarded, load fetch PC <= branch_target, issue no request; first request to branch_target follows the next cycle.
REQ-021 is_branch_taken SHALL take priority over stall, push, and pop in the same cycle.
REQ-022 Latency: request at cycle N, instr_valid=1 at cycle N+2 when the queue was empty; steady state one instruction per cycle with stall=0.

Reset
REQ-023 While reset=1: fetch PC <= RESET_PC, queue empty, in-flight cleared, imem_req=0, instr=16'h0000, instr_valid=0, instr_pc=16'h0000.
REQ-024 First request (addr RESET_PC) SHALL issue in the first cycle with reset=0; reset mid-operation SHALL discard queue and in-flight data immediately.
REQ-025 Reset SHALL take priority over is_branch_taken and stall.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: add outputs fetch_stall_cnt [15:0] (cycles with instr_valid=1 and stall=1) and fetch_flush_cnt [15:0] (cycles with is_branch_taken=1), both saturating at 16'hFFFF, cleared by reset.
REQ-027 FETCH_PERF_CNT_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package cpu_pkg SHALL hold INSTR_W=16, ADDR_W=16, and NOP_INSTR=16'h0000, shared with decode_unit.
REQ-029 Queue storage and pointers SHALL be a sub-module fetch_queue (synchronous FIFO, width 32 = {pc, instr}, depth QDEPTH).

Verification
REQ-030 Reset released, memory holds addr 0..3 = 16'h1111,16'h2222,16'h3333,16'h4444, stall=0 -> instr_valid rises in cycle 2; instr sequence 1111,2222,3333,4444 on consecutive cycles with instr_pc 0..3.
REQ-031 stall=1 for 5 cycles with a full queue -> instr held at same value, imem_req=0 once occupancy+in-flight=4, no instruction lost or duplicated after release.
REQ-032 is_branch_taken=1, branch_target=16'h0040 while a request is in flight -> next cycle instr_valid=0, imem_req=1 with addr 16'h0040; stale response never appears; instr_valid=1 two cycles later with instr_pc=16'h0040.
REQ-033 is_branch_taken=1 and stall=1 in the same cycle -> redirect occurs, queue flushed.
REQ-034 branch_target=16'hFFFE, stall=0 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-035 With FETCH_PERF_CNT_EN: 3 stall cycles with instr_valid=1 plus 2 branches -> fetch_stall_cnt=3, fetch_flush_cnt=2; reset clears both to 0.
